// File: rtl/axi4_mem_slave_burst_if.sv
// AXI4 bus bundle between a master and axi4_mem_slave_burst.
// Carries the AW, W, B, AR and R channels; clock and reset are kept as
// plain ports on the modules that use this bundle.
//   slave modport  : request/data inputs, ready/response outputs
//   master modport : mirror image of slave
interface axi4_mem_slave_burst_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [NB-1:0]         WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_mem_slave_burst.sv
// AXI4 memory slave with independent write and read burst engines over a
// register-array memory. Supports FIXED/INCR/WRAP bursts, byte strobes,
// narrow transfers and SLVERR for illegal bursts or out-of-range beats.
//   ACLK   : clock, rising edge
//   ARESET : asynchronous active-high reset (all outputs forced to 0)
//   bus    : AXI4 slave modport (AW/W/B/AR/R channels)
module axi4_mem_slave_burst #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic                   ACLK,
  input logic                   ARESET,
  axi4_mem_slave_burst_if.slave bus
);
  localparam int unsigned NB        = DATA_WIDTH / 8;
  localparam int unsigned LNB       = $clog2(NB);
  localparam int unsigned IW        = $clog2(MEM_DEPTH);
  localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Whole-burst legality: reserved type, oversize beat, bad WRAP length/alignment.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask;
    logic                  bad_len;
    mask    = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    bad_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || (32'(size) > LNB) ||
           (burst == 2'b10 && (bad_len || (addr & mask) != '0));
  endfunction

  // Address of the beat following addr; arithmetic wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len, input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wmask;
    step  = ADDR_WIDTH'(1) << size;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~wmask) | ((addr + step) & wmask);
      default: return addr + step;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    return 64'(addr) >= 64'(MEM_BYTES);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IW'(addr >> LNB);
  endfunction

  // ---------------- write engine ----------------
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len, w_cnt;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  w_berr, w_err;
  logic                  aw_hs, w_beat, b_hs, w_final, w_mismatch, w_oor, w_err_nxt, mem_we;
  logic                  aw_berr;
  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;

  assign aw_hs      = bus.AWVALID && bus.AWREADY;
  assign w_beat     = bus.WVALID && bus.WREADY;
  assign b_hs       = bus.BVALID && bus.BREADY;
  assign aw_berr    = burst_err(bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST);
  assign w_final    = w_beat && (bus.WLAST || w_cnt == aw_len);
  // Early or missing WLAST taints the response but not the beat itself.
  assign w_mismatch = w_final && (bus.WLAST != (w_cnt == aw_len));
  assign w_oor      = out_of_range(aw_addr);
  assign w_err_nxt  = w_err || (w_beat && (w_oor || w_mismatch));
  assign mem_we     = w_beat && !w_berr && !w_oor;

  // Write state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write next-state.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)   w_next = W_DATA;
      W_DATA:  if (w_final) w_next = W_RESP;
      W_RESP:  if (b_hs)    w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write outputs, decoded from the upcoming state and registered below.
  always_comb begin
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = 1'b0;
    bresp_d   = OKAY;
    case (w_next)
      W_IDLE:  awready_d = 1'b1;
      W_DATA:  wready_d  = 1'b1;
      W_RESP: begin
        bvalid_d = 1'b1;
        bresp_d  = w_err_nxt ? SLVERR : OKAY;
      end
      default: ;
    endcase
  end

  // Write output and burst-context registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= OKAY;
      aw_addr     <= '0;
      aw_len      <= '0;
      aw_size     <= '0;
      aw_burst    <= '0;
      w_cnt       <= '0;
      w_berr      <= 1'b0;
      w_err       <= 1'b0;
    end else begin
      bus.AWREADY <= awready_d;
      bus.WREADY  <= wready_d;
      bus.BVALID  <= bvalid_d;
      bus.BRESP   <= bresp_d;
      if (aw_hs) begin
        aw_addr  <= bus.AWADDR;
        aw_len   <= bus.AWLEN;
        aw_size  <= bus.AWSIZE;
        aw_burst <= bus.AWBURST;
        w_cnt    <= '0;
        w_berr   <= aw_berr;
        w_err    <= aw_berr;
      end else if (w_beat) begin
        aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
        w_cnt   <= w_cnt + 8'd1;
        w_err   <= w_err_nxt;
      end
    end
  end

  // Byte-strobed memory write; contents are not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (bus.WSTRB[b]) mem[word_idx(aw_addr)][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] ar_addr, ld_addr;
  logic [7:0]            ar_len, r_cnt, ld_len, ld_cnt;
  logic [2:0]            ar_size, ld_size;
  logic [1:0]            ar_burst, ld_burst;
  logic                  r_berr, ld_berr, ld_err;
  logic                  ar_hs, r_hs, ld;
  logic                  arready_d, rvalid_d, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            rresp_d;

  assign ar_hs = bus.ARVALID && bus.ARREADY;
  assign r_hs  = bus.RVALID && bus.RREADY;
  assign ld    = ar_hs || (r_hs && !bus.RLAST);

  // Context of the beat to present next: the new burst on AR, else the next beat.
  always_comb begin
    if (ar_hs) begin
      ld_addr  = bus.ARADDR;
      ld_len   = bus.ARLEN;
      ld_size  = bus.ARSIZE;
      ld_burst = bus.ARBURST;
      ld_cnt   = '0;
      ld_berr  = burst_err(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST);
    end else begin
      ld_addr  = ar_addr;
      ld_len   = ar_len;
      ld_size  = ar_size;
      ld_burst = ar_burst;
      ld_cnt   = r_cnt + 8'd1;
      ld_berr  = r_berr;
    end
    ld_err = ld_berr || out_of_range(ld_addr);
  end

  // Read state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read next-state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)                r_next = R_DATA;
      R_DATA:  if (r_hs && bus.RLAST)    r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read outputs; memory is sampled before any same-edge write lands.
  always_comb begin
    arready_d = (r_next == R_IDLE);
    rvalid_d  = (r_next == R_DATA);
    rdata_d   = bus.RDATA;
    rresp_d   = bus.RRESP;
    rlast_d   = bus.RLAST;
    if (r_next == R_IDLE) begin
      rdata_d = '0;
      rresp_d = OKAY;
      rlast_d = 1'b0;
    end else if (ld) begin
      rdata_d = ld_err ? '0 : mem[word_idx(ld_addr)];
      rresp_d = ld_err ? SLVERR : OKAY;
      rlast_d = (ld_cnt == ld_len);
    end
  end

  // Read output and burst-context registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RDATA   <= '0;
      bus.RRESP   <= OKAY;
      bus.RLAST   <= 1'b0;
      ar_addr     <= '0;
      ar_len      <= '0;
      ar_size     <= '0;
      ar_burst    <= '0;
      r_cnt       <= '0;
      r_berr      <= 1'b0;
    end else begin
      bus.ARREADY <= arready_d;
      bus.RVALID  <= rvalid_d;
      bus.RDATA   <= rdata_d;
      bus.RRESP   <= rresp_d;
      bus.RLAST   <= rlast_d;
      if (ld) begin
        ar_addr  <= next_addr(ld_addr, ld_len, ld_size, ld_burst);
        ar_len   <= ld_len;
        ar_size  <= ld_size;
        ar_burst <= ld_burst;
        r_cnt    <= ld_cnt;
        r_berr   <= ld_berr;
      end
    end
  end
endmodule
